// File: rtl/skin_pkg.sv
// Shared constants and helpers for the skin segmentation stage.
package skin_pkg;

  localparam logic [1:0] ADDR_CB_MIN = 2'd0;
  localparam logic [1:0] ADDR_CB_MAX = 2'd1;
  localparam logic [1:0] ADDR_CR_MIN = 2'd2;
  localparam logic [1:0] ADDR_CR_MAX = 2'd3;

  localparam int DEF_CB_MIN = 105;
  localparam int DEF_CB_MAX = 135;
  localparam int DEF_CR_MIN = 125;
  localparam int DEF_CR_MAX = 165;

  typedef struct packed {
    logic [31:0] cnt;
    logic [31:0] xmin;
    logic [31:0] xmax;
    logic [31:0] ymin;
    logic [31:0] ymax;
  } acc_clr_t;

  function automatic logic [31:0] all_ones(input int w);
    return 32'hFFFF_FFFF >> (32 - w);
  endfunction

  // Min trackers start at all-ones so the first skin pixel always wins.
  function automatic acc_clr_t acc_clear(input int x_w, input int y_w);
    acc_clr_t c;
    c.cnt  = '0;
    c.xmin = all_ones(x_w);
    c.xmax = '0;
    c.ymin = all_ones(y_w);
    c.ymax = '0;
    return c;
  endfunction

endpackage

// File: rtl/skin_bin_stats_if.sv
// Video in, threshold config, mask out and per-frame statistics bundle.
interface skin_bin_stats_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 22,
  parameter int X_W    = 11,
  parameter int Y_W    = 11
);
  logic [DATA_W-1:0] cb;
  logic [DATA_W-1:0] cr;
  logic              de_in;
  logic              hsync_in;
  logic              vsync_in;
  logic              cfg_we;
  logic [1:0]        cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic [DATA_W-1:0] bin_rgb;
  logic              de_out;
  logic              hsync_out;
  logic              vsync_out;
  logic [CNT_W-1:0]  skin_count;
  logic [X_W-1:0]    bbox_xmin;
  logic [X_W-1:0]    bbox_xmax;
  logic [Y_W-1:0]    bbox_ymin;
  logic [Y_W-1:0]    bbox_ymax;
  logic              stats_valid;

  modport master (
    output cb, cr, de_in, hsync_in, vsync_in, cfg_we, cfg_addr, cfg_data,
    input  bin_rgb, de_out, hsync_out, vsync_out, skin_count,
           bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax, stats_valid
  );

  modport slave (
    input  cb, cr, de_in, hsync_in, vsync_in, cfg_we, cfg_addr, cfg_data,
    output bin_rgb, de_out, hsync_out, vsync_out, skin_count,
           bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax, stats_valid
  );
endinterface

// File: rtl/skin_stats_acc.sv
// Stage-2 pixel coordinates, frame-start detect and per-frame skin statistics.
// Statistics publish one cycle after frame start and hold until the next one.
module skin_stats_acc
  import skin_pkg::*;
#(
  parameter int CNT_W = 22,
  parameter int X_W   = 11,
  parameter int Y_W   = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             de,
  input  logic             vsync,
  input  logic             skin,
  output logic             frame_start,
  output logic             stats_valid,
  output logic [CNT_W-1:0] skin_count,
  output logic [X_W-1:0]   bbox_xmin,
  output logic [X_W-1:0]   bbox_xmax,
  output logic [Y_W-1:0]   bbox_ymin,
  output logic [Y_W-1:0]   bbox_ymax
);

  localparam acc_clr_t CLR = acc_clear(X_W, Y_W);
  localparam logic [CNT_W-1:0] CNT_CLR  = CLR.cnt[CNT_W-1:0];
  localparam logic [X_W-1:0]   XMIN_CLR = CLR.xmin[X_W-1:0];
  localparam logic [X_W-1:0]   XMAX_CLR = CLR.xmax[X_W-1:0];
  localparam logic [Y_W-1:0]   YMIN_CLR = CLR.ymin[Y_W-1:0];
  localparam logic [Y_W-1:0]   YMAX_CLR = CLR.ymax[Y_W-1:0];

  logic             vs_prev_q, vs_prev_d, de_prev_q, de_prev_d, seen_q, seen_d;
  logic [X_W-1:0]   x_q, x_d, xmin_q, xmin_d, xmax_q, xmax_d;
  logic [Y_W-1:0]   y_q, y_d, y_pix, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sv_q, sv_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [X_W-1:0]   pxmin_q, pxmin_d, pxmax_q, pxmax_d;
  logic [Y_W-1:0]   pymin_q, pymin_d, pymax_q, pymax_d;
  logic             publish;

  always_comb begin
    frame_start = vsync & ~vs_prev_q;
    vs_prev_d   = vsync;
    de_prev_d   = de;
    seen_d      = seen_q | frame_start;

    x_d = de ? ((&x_q) ? x_q : x_q + 1'b1) : '0;
    if (frame_start)                    y_d = '0;
    else if (!de && de_prev_q && !(&y_q)) y_d = y_q + 1'b1;
    else                                y_d = y_q;
    // A pixel coinciding with frame start is row 0 of the new frame.
    y_pix = frame_start ? '0 : y_q;

    cnt_d  = frame_start ? CNT_CLR  : cnt_q;
    xmin_d = frame_start ? XMIN_CLR : xmin_q;
    xmax_d = frame_start ? XMAX_CLR : xmax_q;
    ymin_d = frame_start ? YMIN_CLR : ymin_q;
    ymax_d = frame_start ? YMAX_CLR : ymax_q;
    if (skin) begin
      if (!(&cnt_d)) cnt_d = cnt_d + 1'b1;
      if (x_q < xmin_d)   xmin_d = x_q;
      if (x_q > xmax_d)   xmax_d = x_q;
      if (y_pix < ymin_d) ymin_d = y_pix;
      if (y_pix > ymax_d) ymax_d = y_pix;
    end

    // Anything gathered before the first frame start is a partial frame.
    publish = seen_q && (cnt_q != '0);
    sv_d    = frame_start;
    pcnt_d  = pcnt_q;
    pxmin_d = pxmin_q;
    pxmax_d = pxmax_q;
    pymin_d = pymin_q;
    pymax_d = pymax_q;
    if (frame_start) begin
      pcnt_d  = seen_q  ? cnt_q  : '0;
      pxmin_d = publish ? xmin_q : '0;
      pxmax_d = publish ? xmax_q : '0;
      pymin_d = publish ? ymin_q : '0;
      pymax_d = publish ? ymax_q : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev_q <= 1'b0;
      de_prev_q <= 1'b0;
      seen_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      cnt_q     <= CNT_CLR;
      xmin_q    <= XMIN_CLR;
      xmax_q    <= XMAX_CLR;
      ymin_q    <= YMIN_CLR;
      ymax_q    <= YMAX_CLR;
      sv_q      <= 1'b0;
      pcnt_q    <= '0;
      pxmin_q   <= '0;
      pxmax_q   <= '0;
      pymin_q   <= '0;
      pymax_q   <= '0;
    end else begin
      vs_prev_q <= vs_prev_d;
      de_prev_q <= de_prev_d;
      seen_q    <= seen_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      xmin_q    <= xmin_d;
      xmax_q    <= xmax_d;
      ymin_q    <= ymin_d;
      ymax_q    <= ymax_d;
      sv_q      <= sv_d;
      pcnt_q    <= pcnt_d;
      pxmin_q   <= pxmin_d;
      pxmax_q   <= pxmax_d;
      pymin_q   <= pymin_d;
      pymax_q   <= pymax_d;
    end
  end

  assign stats_valid = sv_q;
  assign skin_count  = pcnt_q;
  assign bbox_xmin   = pxmin_q;
  assign bbox_xmax   = pxmax_q;
  assign bbox_ymin   = pymin_q;
  assign bbox_ymax   = pymax_q;

endmodule

// File: rtl/skin_bin_stats.sv
// Chroma-threshold skin mask with 2-cycle aligned syncs and per-frame statistics.
// Thresholds are shadowed and become active on the stage-2 vsync rising edge.
module skin_bin_stats
  import skin_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 22,
  parameter int X_W        = 11,
  parameter int Y_W        = 11,
  parameter int CB_MIN_DEF = DEF_CB_MIN,
  parameter int CB_MAX_DEF = DEF_CB_MAX,
  parameter int CR_MIN_DEF = DEF_CR_MIN,
  parameter int CR_MAX_DEF = DEF_CR_MAX
) (
  input logic             clk,
  input logic             rst,
  skin_bin_stats_if.slave vid
);

  localparam logic [3:0][DATA_W-1:0] THR_DEF = {
    DATA_W'(CR_MAX_DEF), DATA_W'(CR_MIN_DEF), DATA_W'(CB_MAX_DEF), DATA_W'(CB_MIN_DEF)
  };

  logic [DATA_W-1:0]      cb1_q, cb1_d, cr1_q, cr1_d;
  logic                   de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [DATA_W-1:0]      bin_q, bin_d;
  logic                   de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d;
  logic [3:0][DATA_W-1:0] shd_q, shd_d, act_q, act_d;
  logic                   skin, frame_start;

  always_comb begin
    cb1_d = vid.cb;
    cr1_d = vid.cr;
    de1_d = vid.de_in;
    hs1_d = vid.hsync_in;
    vs1_d = vid.vsync_in;

    shd_d = shd_q;
    if (vid.cfg_we) shd_d[vid.cfg_addr] = vid.cfg_data;
    // Copy from shd_d so a write landing on the frame-start cycle is taken.
    act_d = frame_start ? shd_d : act_q;

    skin = de1_q
        && (cb1_q > act_q[ADDR_CB_MIN]) && (cb1_q < act_q[ADDR_CB_MAX])
        && (cr1_q > act_q[ADDR_CR_MIN]) && (cr1_q < act_q[ADDR_CR_MAX]);
    bin_d = skin ? '1 : '0;
    de2_d = de1_q;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cb1_q <= '0;
      cr1_q <= '0;
      de1_q <= 1'b0;
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      bin_q <= '0;
      de2_q <= 1'b0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
      shd_q <= THR_DEF;
      act_q <= THR_DEF;
    end else begin
      cb1_q <= cb1_d;
      cr1_q <= cr1_d;
      de1_q <= de1_d;
      hs1_q <= hs1_d;
      vs1_q <= vs1_d;
      bin_q <= bin_d;
      de2_q <= de2_d;
      hs2_q <= hs2_d;
      vs2_q <= vs2_d;
      shd_q <= shd_d;
      act_q <= act_d;
    end
  end

  assign vid.bin_rgb   = bin_q;
  assign vid.de_out    = de2_q;
  assign vid.hsync_out = hs2_q;
  assign vid.vsync_out = vs2_q;

  skin_stats_acc #(
    .CNT_W (CNT_W),
    .X_W   (X_W),
    .Y_W   (Y_W)
  ) u_acc (
    .clk         (clk),
    .rst         (rst),
    .de          (de2_q),
    .vsync       (vs2_q),
    .skin        (bin_q[0]),
    .frame_start (frame_start),
    .stats_valid (vid.stats_valid),
    .skin_count  (vid.skin_count),
    .bbox_xmin   (vid.bbox_xmin),
    .bbox_xmax   (vid.bbox_xmax),
    .bbox_ymin   (vid.bbox_ymin),
    .bbox_ymax   (vid.bbox_ymax)
  );

endmodule

// File: tb/tb_skin_bin_stats.sv
// Directed bench for skin_bin_stats: mask thresholds, alignment, shadowing, stats, reset.
module tb_skin_bin_stats;
  import skin_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;

  int          pulses;
  logic [21:0] cap_cnt;
  logic [10:0] cap_xmin, cap_xmax, cap_ymin, cap_ymax;
  logic [3:0]  cap_sat_cnt;

  always #5 clk = ~clk;

  skin_bin_stats_if #(.DATA_W(8), .CNT_W(22), .X_W(11), .Y_W(11)) ifm ();
  skin_bin_stats_if #(.DATA_W(8), .CNT_W(4),  .X_W(11), .Y_W(11)) ifs ();

  assign ifs.cb       = ifm.cb;
  assign ifs.cr       = ifm.cr;
  assign ifs.de_in    = ifm.de_in;
  assign ifs.hsync_in = ifm.hsync_in;
  assign ifs.vsync_in = ifm.vsync_in;
  assign ifs.cfg_we   = ifm.cfg_we;
  assign ifs.cfg_addr = ifm.cfg_addr;
  assign ifs.cfg_data = ifm.cfg_data;

  skin_bin_stats #(.DATA_W(8), .CNT_W(22), .X_W(11), .Y_W(11)) dut (
    .clk (clk), .rst (rst), .vid (ifm.slave)
  );

  skin_bin_stats #(.DATA_W(8), .CNT_W(4), .X_W(11), .Y_W(11)) dut_sat (
    .clk (clk), .rst (rst), .vid (ifs.slave)
  );

  // One pixel per call; outputs seen on return reflect the previous call.
  task automatic px(input logic [7:0] c_b, input logic [7:0] c_r,
                    input logic de, input logic hs, input logic vs);
    ifm.cb = c_b; ifm.cr = c_r;
    ifm.de_in = de; ifm.hsync_in = hs; ifm.vsync_in = vs;
    @(negedge clk);
    if (ifm.stats_valid) begin
      pulses++;
      cap_cnt  = ifm.skin_count;
      cap_xmin = ifm.bbox_xmin; cap_xmax = ifm.bbox_xmax;
      cap_ymin = ifm.bbox_ymin; cap_ymax = ifm.bbox_ymax;
    end
    if (ifs.stats_valid) cap_sat_cnt = ifs.skin_count;
  endtask

  task automatic cfg_px(input logic [1:0] a, input logic [7:0] d,
                        input logic [7:0] c_b, input logic de, input logic vs);
    ifm.cfg_we = 1'b1; ifm.cfg_addr = a; ifm.cfg_data = d;
    px(c_b, 8'd140, de, 1'b0, vs);
    ifm.cfg_we = 1'b0;
  endtask

  task automatic vsync_block();
    pulses = 0;
    for (int i = 0; i < 3; i++) px(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) px(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rows(input int x0, input int x1, input int y0, input int y1);
    for (int y = 0; y < 48; y++) begin
      for (int i = 0; i < 2; i++) px(8'd80, 8'd140, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) px(8'd80, 8'd140, 1'b0, 1'b0, 1'b0);
      for (int x = 0; x < 64; x++)
        px((x >= x0 && x <= x1 && y >= y0 && y <= y1) ? 8'd120 : 8'd80,
           8'd140, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) px(8'd80, 8'd140, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic check_stats(input string tag, input logic [21:0] c,
                             input logic [10:0] x0, input logic [10:0] x1,
                             input logic [10:0] y0, input logic [10:0] y1);
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL %s stats_valid pulses got %0d want 1", tag, pulses);
    end
    checks++;
    if ({cap_cnt, cap_xmin, cap_xmax, cap_ymin, cap_ymax} !== {c, x0, x1, y0, y1}) begin
      errors++;
      $display("FAIL %s stats got cnt=%0d bbox=%0d,%0d,%0d,%0d want cnt=%0d bbox=%0d,%0d,%0d,%0d",
               tag, cap_cnt, cap_xmin, cap_xmax, cap_ymin, cap_ymax, c, x0, x1, y0, y1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ifm.cb = '0; ifm.cr = '0; ifm.de_in = 0; ifm.hsync_in = 0; ifm.vsync_in = 0;
    ifm.cfg_we = 0; ifm.cfg_addr = '0; ifm.cfg_data = '0;
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({ifm.bin_rgb, ifm.de_out, ifm.hsync_out, ifm.vsync_out, ifm.stats_valid,
         ifm.skin_count, ifm.bbox_xmin, ifm.bbox_xmax, ifm.bbox_ymin, ifm.bbox_ymax} !== '0) begin
      errors++; $display("FAIL reset_outputs got bin=%0h cnt=%0d want all zero", ifm.bin_rgb, ifm.skin_count);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_thresholds();
    logic [7:0] tcb [8] = '{8'd120, 8'd105, 8'd106, 8'd134, 8'd135, 8'd120, 8'd120, 8'd120};
    logic [7:0] tcr [8] = '{8'd140, 8'd140, 8'd140, 8'd140, 8'd140, 8'd125, 8'd126, 8'd165};
    logic [7:0] texp[8] = '{8'hFF,  8'h00,  8'hFF,  8'hFF,  8'h00,  8'h00,  8'hFF,  8'h00};
    px(8'd120, 8'd140, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ifm.bin_rgb !== 8'h00) begin
      errors++; $display("FAIL latency_1cyc bin got %0h want 00", ifm.bin_rgb);
    end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) px(tcb[i], tcr[i], 1'b1, 1'b0, 1'b0);
      px(tcb[i], tcr[i], 1'b1, 1'b0, 1'b0);
      checks++;
      if (ifm.bin_rgb !== texp[i]) begin
        errors++;
        $display("FAIL thr_default cb=%0d cr=%0d bin got %0h want %0h", tcb[i], tcr[i], ifm.bin_rgb, texp[i]);
      end
    end
    px(8'd120, 8'd140, 1'b0, 1'b0, 1'b0);
    px(8'd120, 8'd140, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ifm.bin_rgb !== 8'h00) begin
      errors++; $display("FAIL de_qualify bin got %0h want 00", ifm.bin_rgb);
    end
  endtask

  task automatic test_alignment();
    logic [2:0] cur, prev;
    prev = 3'b000;
    for (int i = 0; i < 48; i++) begin
      cur = 3'($urandom_range(0, 7));
      px(8'd120, 8'd140, cur[2], cur[1], cur[0]);
      if (i > 0) begin
        checks++;
        if ({ifm.de_out, ifm.hsync_out, ifm.vsync_out, ifm.bin_rgb} !== {prev, {8{prev[2]}}}) begin
          errors++;
          $display("FAIL align cyc %0d got de/hs/vs=%b%b%b bin=%0h want %b bin=%0h", i,
                   ifm.de_out, ifm.hsync_out, ifm.vsync_out, ifm.bin_rgb, prev, {8{prev[2]}});
        end
      end
      prev = cur;
    end
    for (int i = 0; i < 3; i++) px(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_shadow();
    for (int i = 0; i < 3; i++) px(8'd120, 8'd140, 1'b1, 1'b0, 1'b0);
    cfg_px(ADDR_CB_MAX, 8'd110, 8'd120, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      px(8'd120, 8'd140, 1'b1, 1'b0, 1'b0);
      checks++;
      if (ifm.bin_rgb !== 8'hFF) begin
        errors++; $display("FAIL shadow_hold cyc %0d bin got %0h want ff", i, ifm.bin_rgb);
      end
    end
    for (int i = 0; i < 6; i++) px(8'd120, 8'd140, 1'b1, 1'b0, 1'b1);
    checks++;
    if (ifm.bin_rgb !== 8'h00) begin
      errors++; $display("FAIL shadow_apply bin got %0h want 00", ifm.bin_rgb);
    end
    for (int i = 0; i < 4; i++) px(8'd120, 8'd140, 1'b1, 1'b0, 1'b0);
    px(8'd120, 8'd140, 1'b1, 1'b0, 1'b1);
    px(8'd120, 8'd140, 1'b1, 1'b0, 1'b1);
    cfg_px(ADDR_CB_MAX, 8'd135, 8'd120, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) px(8'd120, 8'd140, 1'b1, 1'b0, 1'b1);
    checks++;
    if (ifm.bin_rgb !== 8'hFF) begin
      errors++; $display("FAIL write_first bin got %0h want ff", ifm.bin_rgb);
    end
    for (int i = 0; i < 3; i++) px(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stats();
    vsync_block();
    rows(10, 19, 5, 7);
    vsync_block();
    check_stats("stats_rect", 22'd30, 11'd10, 11'd19, 11'd5, 11'd7);
  endtask

  task automatic test_empty_and_sat();
    rows(0, -1, 0, -1);
    vsync_block();
    check_stats("empty_frame", 22'd0, 11'd0, 11'd0, 11'd0, 11'd0);
    rows(10, 19, 5, 6);
    vsync_block();
    check_stats("sat_main", 22'd20, 11'd10, 11'd19, 11'd5, 11'd6);
    checks++;
    if (cap_sat_cnt !== 4'd15) begin
      errors++; $display("FAIL sat_count got %0d want 15", cap_sat_cnt);
    end
  endtask

  task automatic test_async_reset();
    cfg_px(ADDR_CB_MIN, 8'd200, 8'd0, 1'b0, 1'b0);
    vsync_block();
    for (int i = 0; i < 3; i++) px(8'd120, 8'd140, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ifm.bin_rgb !== 8'h00 || ifm.de_out !== 1'b1) begin
      errors++; $display("FAIL pre_reset bin got %0h de %b want 00 1", ifm.bin_rgb, ifm.de_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ifm.de_out, ifm.skin_count, ifm.bbox_xmax, ifm.bbox_ymax, ifm.stats_valid} !== '0) begin
      errors++;
      $display("FAIL async_reset got de=%b cnt=%0d xmax=%0d ymax=%0d want all zero",
               ifm.de_out, ifm.skin_count, ifm.bbox_xmax, ifm.bbox_ymax);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) px(8'd120, 8'd140, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ifm.bin_rgb !== 8'hFF) begin
      errors++; $display("FAIL reset_thr_default bin got %0h want ff", ifm.bin_rgb);
    end
    px(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    vsync_block();
    check_stats("first_after_reset", 22'd0, 11'd0, 11'd0, 11'd0, 11'd0);
    rows(3, 40, 10, 11);
    vsync_block();
    check_stats("post_reset_frame", 22'd76, 11'd3, 11'd40, 11'd10, 11'd11);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    pulses = 0;
    cap_cnt = '0; cap_xmin = '0; cap_xmax = '0; cap_ymin = '0; cap_ymax = '0;
    cap_sat_cnt = '0;
    test_reset();
    test_thresholds();
    test_alignment();
    test_shadow();
    test_stats();
    test_empty_and_sat();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/skin_bin_stats.md
# skin_bin_stats

Parametrised skin-colour segmentation stage for the neuro_skin video path. It takes Cb/Cr chroma and DE/HSYNC/VSYNC timing, and emits a binary mask (all-ones or zero) with the sync signals pipeline-aligned to it. Cb/Cr thresholds are runtime-programmable and applied at frame boundaries. Per-frame statistics (skin pixel count, bounding box) are accumulated and published at each frame start for the downstream hand-tracking logic.

## Interface
- DATA_W, 8, chroma and mask width
- CNT_W, 22, skin pixel counter width; saturating
- X_W, 11, column coordinate width
- Y_W, 11, row coordinate width
- CB_MIN_DEF / CB_MAX_DEF, 105 / 135, reset thresholds for Cb
- CR_MIN_DEF / CR_MAX_DEF, 125 / 165, reset thresholds for Cr
- clk  in  1  pixel clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- cb, cr  in  DATA_W  chroma samples
- de_in, hsync_in, vsync_in  in  1  video timing; vsync active-high
- cfg_we  in  1  threshold write strobe
- cfg_addr  in  2  0=CB_MIN, 1=CB_MAX, 2=CR_MIN, 3=CR_MAX
- cfg_data  in  DATA_W  threshold value
- bin_rgb  out  DATA_W  mask: all-ones = skin, 0 = not skin
- de_out, hsync_out, vsync_out  out  1  timing, aligned with bin_rgb
- skin_count  out  CNT_W  skin pixels in the last completed frame
- bbox_xmin, bbox_xmax  out  X_W  skin bounding box columns, last frame
- bbox_ymin, bbox_ymax  out  Y_W  skin bounding box rows, last frame
- stats_valid  out  1  one-cycle pulse when the statistics outputs update

## Operation
- Skin test: (cb > CB_MIN) && (cb < CB_MAX) && (cr > CR_MIN) && (cr < CR_MAX).
  - All bounds are exclusive and compared unsigned.
  - The test is qualified by DE: bin_rgb = 0 whenever the aligned DE is low.
- Thresholds:
  - cfg_we writes cfg_data into the shadow register selected by cfg_addr.
  - The active registers copy all four shadows on the frame-start cycle.
  - A cfg write on the frame-start cycle is included in that copy (write-first).
  - min >= max for either channel yields no skin pixels; this is legal.
- Frame start: the rising edge of vsync at pipeline stage 2 (vsync high, previous value low).
- Coordinates, tracked at stage 2:
  - x counts DE-high pixels within a line and resets to 0 while DE is low.
  - y resets to 0 at frame start and increments on each DE falling edge.
  - x and y saturate at their all-ones value.
- Accumulators:
  - For each skin pixel: count += 1 (saturating); xmin/xmax/ymin/ymax update with the pixel's (x, y).
  - Clear values: count = 0, xmin/ymin = all-ones, xmax/ymax = 0.
- On frame start:
  - Copy the accumulators to the stat outputs and pulse stats_valid.
  - Clear the accumulators.
  - A stage-2 pixel on the same cycle belongs to the new frame.
- Empty frame (count = 0): all four bbox outputs publish 0.
- The first frame start after reset publishes count 0 and bbox 0.

## Timing
- Latency: 2 cycles from cb/cr/sync input to bin_rgb/de_out/hsync_out/vsync_out.
  - Stage 1 registers the inputs.
  - Stage 2 registers the compare result and the delayed syncs.
- All three sync outputs share the same 2-cycle delay; their relative alignment is preserved exactly.
- stats_valid asserts on the cycle after vsync_out first goes high, i.e. 3 cycles after the vsync_in rising edge. The stat outputs change on that same edge and hold until the next pulse.
- Reset values:
  - bin_rgb, de_out, hsync_out, vsync_out, stats_valid, skin_count, bbox_*: 0.
  - Shadow and active thresholds: *_DEF.
  - Accumulators: clear values.
  - Pipeline vsync history: 0, so a vsync held high through reset release counts as a frame start once stage 2 sees it.
- Reset mid-frame discards the partial statistics; no stats_valid pulse is generated by the reset itself.
- No backpressure: one pixel is accepted every clock.

## Structure
- skin_pkg holds:
  - cfg address constants (ADDR_CB_MIN..ADDR_CR_MAX);
  - default threshold localparams;
  - a function returning the accumulator clear values for given widths.
- Sub-module skin_stats_acc holds the x/y counters, frame-start detect, accumulators and output latch.
- Top level holds the threshold registers, the 2-stage compare pipeline and the sync delay.

## Test plan
- Reset defaults:
  - Stimulus: cb=120, cr=140, DE=1 steady.
  - Required: bin_rgb=0xFF exactly 2 cycles later.
  - Stimulus: cb=105.
  - Required: bin_rgb=0x00 (exclusive bound).
- Alignment:
  - Stimulus: random DE/HSYNC/VSYNC pattern.
  - Required: outputs equal the inputs delayed by 2 cycles; bin_rgb=0 whenever de_out=0.
- Threshold shadowing:
  - Stimulus: write CB_MAX=110 mid-frame.
  - Required: cb=120 is still skin until the next vsync rising edge, and not skin afterwards.
  - Stimulus: a write on the frame-start cycle.
  - Required: it takes effect in that frame.
- Statistics:
  - Stimulus: 64x48 frame with a skin rectangle at columns 10..19, rows 5..7.
  - Required: at the next frame start, stats_valid is a single pulse; count=30, xmin=10, xmax=19, ymin=5, ymax=7.
- Empty frame and saturation:
  - Stimulus: frame with no skin.
  - Required: count=0, all bbox=0.
  - Stimulus: CNT_W=4 with 20 skin pixels.
  - Required: count=15.
- Async reset:
  - Stimulus: assert rst mid-line.
  - Required: all outputs 0 immediately without a clock edge; thresholds revert to defaults.
  - Stimulus: the next full frame.
  - Required: statistics are correct.
